// File: rtl/alu_packet_ctrl.sv
// Packet sequencer between the UART AXI-stream byte ports and the ALU datapath.
// Parses host packets (opcode, reserved, LEN lo, LEN hi, payload) and either
// echoes the payload, sums 32-bit words, or multiplies them through an external
// multiplier. Results go back little-endian on the TX stream.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// HDR0      | idle, waiting for opcode byte
// HDR1      | waiting for reserved byte
// HDR2      | waiting for LEN[7:0]
// HDR3      | waiting for LEN[15:8], then validate the packet
// DRAIN     | discard remaining payload bytes of a rejected packet
// PAYLOAD   | consume payload (echo passthrough or word assembly)
// MUL_REQ   | multiplier request pending, waiting for mul_ready_i
// MUL_WAIT  | waiting for mul_done_i
// RESP      | send the 4 accumulator bytes, LSB first
module alu_packet_ctrl #(
    parameter int DATA_WIDTH_P     = 8,
    parameter int TIMEOUT_CYCLES_P = 3225600
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH_P-1:0] rx_tdata_i,
    input  logic                    rx_tvalid_i,
    output logic                    rx_tready_o,
    output logic [DATA_WIDTH_P-1:0] tx_tdata_o,
    output logic                    tx_tvalid_o,
    input  logic                    tx_tready_i,
    output logic                    mul_valid_o,
    input  logic                    mul_ready_i,
    output logic [31:0]             mul_a_o,
    output logic [31:0]             mul_b_o,
    input  logic                    mul_done_i,
    input  logic [31:0]             mul_result_i,
    output logic                    busy_o,
    output logic                    err_o,
    output logic [1:0]              err_code_o
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES_P + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES_P - 1);
    localparam logic [7:0]    OP_ECHO  = 8'hEC;
    localparam logic [7:0]    OP_ADD   = 8'hA1;
    localparam logic [7:0]    OP_MUL   = 8'hB2;

    typedef enum logic [3:0] {
        S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_DRAIN,
        S_PAYLOAD, S_MUL_REQ, S_MUL_WAIT, S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    opcode_q, opcode_d;
    logic [7:0]    len_lo_q, len_lo_d;
    logic [15:0]   rem_q, rem_d;
    logic [23:0]   word_q, word_d;
    logic          first_q, first_d;
    logic [31:0]   acc_q, acc_d;
    logic [1:0]    bidx_q, bidx_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          mul_valid_q, mul_valid_d;
    logic [31:0]   mul_a_q, mul_a_d;
    logic [31:0]   mul_b_q, mul_b_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic        rx_xfer;
    logic        tx_xfer;
    logic        is_echo;
    logic [15:0] len_full;
    logic [15:0] drain_len;
    logic [31:0] word_full;
    logic        counting;
    logic        abort_ok;

    assign rx_byte   = rx_tdata_i;
    assign is_echo   = (opcode_q == OP_ECHO);
    assign len_full  = {rx_byte, len_lo_q};
    assign drain_len = (len_full > 16'd4) ? (len_full - 16'd4) : 16'd0;
    assign word_full = {rx_byte, word_q};

    // RX acceptance depends only on state and TX backpressure
    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            S_HDR0, S_HDR1, S_HDR2, S_HDR3: rx_ready = 1'b1;
            S_DRAIN:   rx_ready = (rem_q != 16'd0);
            S_PAYLOAD: rx_ready = is_echo ? ((rem_q != 16'd0) && (!tx_valid_q || tx_tready_i))
                                          : 1'b1;
            default:   rx_ready = 1'b0;
        endcase
    end

    assign rx_xfer = rx_tvalid_i & rx_ready;
    assign tx_xfer = tx_tvalid_o & tx_tready_i;

    // Next-state, datapath and timeout logic
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        len_lo_d    = len_lo_q;
        rem_d       = rem_q;
        word_d      = word_q;
        first_d     = first_q;
        acc_d       = acc_q;
        bidx_d      = bidx_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        mul_valid_d = mul_valid_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        tmo_d       = tmo_q;

        case (state_q)
            S_HDR0: if (rx_xfer) begin
                opcode_d = rx_byte;
                state_d  = S_HDR1;
            end
            S_HDR1: if (rx_xfer) state_d = S_HDR2;
            S_HDR2: if (rx_xfer) begin
                len_lo_d = rx_byte;
                state_d  = S_HDR3;
            end
            S_HDR3: if (rx_xfer) begin
                rem_d   = len_full - 16'd4;
                first_d = 1'b1;
                if (!(is_echo || opcode_q == OP_ADD || opcode_q == OP_MUL)) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                    rem_d      = drain_len;
                    state_d    = S_DRAIN;
                end else if (is_echo) begin
                    if (len_full < 16'd4) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                        rem_d      = 16'd0;
                        state_d    = S_DRAIN;
                    end else if (len_full == 16'd4) begin
                        state_d = S_HDR0;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end else if (len_full < 16'd8 || len_full[1:0] != 2'd0) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    rem_d      = drain_len;
                    state_d    = S_DRAIN;
                end else begin
                    state_d = S_PAYLOAD;
                end
            end
            S_DRAIN: begin
                if (rem_q == 16'd0) begin
                    state_d = S_HDR0;
                end else if (rx_xfer) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = S_HDR0;
                end
            end
            S_PAYLOAD: begin
                if (is_echo) begin
                    if (tx_xfer) tx_valid_d = 1'b0;
                    if (rx_xfer) begin
                        tx_data_d  = rx_byte;
                        tx_valid_d = 1'b1;
                        rem_d      = rem_q - 16'd1;
                    end else if (rem_q == 16'd0 && tx_xfer) begin
                        state_d = S_HDR0;
                    end
                end else if (rx_xfer) begin
                    rem_d  = rem_q - 16'd1;
                    word_d = {rx_byte, word_q[23:8]};
                    // rem counts down from a multiple of 4, so rem%4==1 marks the 4th byte
                    if (rem_q[1:0] == 2'd1) begin
                        first_d = 1'b0;
                        if (first_q) begin
                            acc_d = word_full;
                        end else if (opcode_q == OP_ADD) begin
                            acc_d = acc_q + word_full;
                        end
                        if (!first_q && opcode_q == OP_MUL) begin
                            mul_valid_d = 1'b1;
                            mul_a_d     = acc_q;
                            mul_b_d     = word_full;
                            state_d     = S_MUL_REQ;
                        end else if (rem_q == 16'd1) begin
                            bidx_d  = 2'd0;
                            state_d = S_RESP;
                        end
                    end
                end
            end
            S_MUL_REQ: if (mul_ready_i) begin
                mul_valid_d = 1'b0;
                state_d     = S_MUL_WAIT;
            end
            S_MUL_WAIT: if (mul_done_i) begin
                acc_d   = mul_result_i;
                bidx_d  = 2'd0;
                state_d = (rem_q == 16'd0) ? S_RESP : S_PAYLOAD;
            end
            S_RESP: if (tx_xfer) begin
                bidx_d = bidx_q + 2'd1;
                if (bidx_q == 2'd3) state_d = S_HDR0;
            end
            default: state_d = S_HDR0;
        endcase

        // Inter-byte timeout; echo waits for a pending TX byte before aborting,
        // and an echo whose payload is fully received is never aborted
        counting = (state_q == S_HDR1) || (state_q == S_HDR2) || (state_q == S_HDR3) ||
                   (state_q == S_DRAIN) || (state_q == S_PAYLOAD);
        abort_ok = !((state_q == S_PAYLOAD) && is_echo &&
                     ((rem_q == 16'd0) || (tx_valid_q && !tx_tready_i)));
        if (rx_xfer) begin
            tmo_d = '0;
        end else if (counting) begin
            if (tmo_q >= TMO_LAST) begin
                if (abort_ok) begin
                    state_d     = S_HDR0;
                    tx_valid_d  = 1'b0;
                    mul_valid_d = 1'b0;
                    err_d       = 1'b1;
                    err_code_d  = 2'd3;
                end
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
        if (state_d != state_q) tmo_d = '0;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HDR0;
            opcode_q    <= '0;
            len_lo_q    <= '0;
            rem_q       <= '0;
            word_q      <= '0;
            first_q     <= 1'b0;
            acc_q       <= '0;
            bidx_q      <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            len_lo_q    <= len_lo_d;
            rem_q       <= rem_d;
            word_q      <= word_d;
            first_q     <= first_d;
            acc_q       <= acc_d;
            bidx_q      <= bidx_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            mul_valid_q <= mul_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            tmo_q       <= tmo_d;
        end
    end

    assign rx_tready_o = rx_ready;
    // RESP drives the TX port straight from the accumulator byte lane
    assign tx_tvalid_o = tx_valid_q | (state_q == S_RESP);
    assign tx_tdata_o  = (state_q == S_RESP) ? acc_q[{bidx_q, 3'b000} +: 8] : tx_data_q;
    assign mul_valid_o = mul_valid_q;
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;
    assign busy_o      = (state_q != S_HDR0);
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_alu_packet_ctrl.sv
// Bench for alu_packet_ctrl: a packet-level model predicts TX bytes, multiplier
// requests and error codes; one compare process checks the DUT every cycle.
module tb_alu_packet_ctrl;

    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_tdata_i;
    logic        rx_tvalid_i;
    logic        rx_tready_o;
    logic [7:0]  tx_tdata_o;
    logic        tx_tvalid_o;
    logic        tx_tready_i;
    logic        mul_valid_o;
    logic        mul_ready_i;
    logic [31:0] mul_a_o;
    logic [31:0] mul_b_o;
    logic        mul_done_i;
    logic [31:0] mul_result_i;
    logic        busy_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    always #5 clk = ~clk;

    alu_packet_ctrl #(.DATA_WIDTH_P(8), .TIMEOUT_CYCLES_P(T)) dut (
        .clk(clk), .rst(rst),
        .rx_tdata_i(rx_tdata_i), .rx_tvalid_i(rx_tvalid_i), .rx_tready_o(rx_tready_o),
        .tx_tdata_o(tx_tdata_o), .tx_tvalid_o(tx_tvalid_o), .tx_tready_i(tx_tready_i),
        .mul_valid_o(mul_valid_o), .mul_ready_i(mul_ready_i),
        .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_done_i(mul_done_i), .mul_result_i(mul_result_i),
        .busy_o(busy_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    int vectors = 0;
    int miscompares = 0;
    int tx_count = 0;
    int tx_mode = 3;      // 0 random, 1 toggle, 2 always ready, 3 never ready

    byte unsigned  exp_tx[$];
    int            exp_err[$];
    logic [63:0]   exp_mul[$];
    byte unsigned  m_tx[$];
    logic [63:0]   m_mul[$];
    int            m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // Packet-level reference: what one packet must produce
    function automatic void model_pkt(input byte unsigned p[$]);
        logic [15:0] len;
        logic [31:0] acc, w;
        int nw;
        m_tx.delete();
        m_mul.delete();
        m_err = 0;
        acc = 0;
        len = {p[3], p[2]};
        if (p[0] != 8'hEC && p[0] != 8'hA1 && p[0] != 8'hB2) begin
            m_err = 1;
        end else if (p[0] == 8'hEC) begin
            if (len < 4) m_err = 2;
            else for (int i = 4; i < int'(len); i++) m_tx.push_back(p[i]);
        end else if (len < 8 || (len % 4) != 0) begin
            m_err = 2;
        end else begin
            nw = (int'(len) - 4) / 4;
            for (int k = 0; k < nw; k++) begin
                w = {p[4*k+7], p[4*k+6], p[4*k+5], p[4*k+4]};
                if (k == 0) acc = w;
                else if (p[0] == 8'hA1) acc = acc + w;
                else begin
                    m_mul.push_back({acc, w});
                    acc = acc * w;
                end
            end
            for (int b = 0; b < 4; b++) m_tx.push_back(byte'(acc >> (8*b)));
        end
    endfunction

    task automatic pin_tx(input string name, input byte unsigned lit[$]);
        check({name, "_len"}, m_tx.size(), lit.size());
        if (m_tx.size() == lit.size())
            foreach (lit[i]) check({name, "_byte"}, m_tx[i], lit[i]);
    endtask

    // TX backpressure generator
    initial begin
        tx_tready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (tx_mode)
                0: tx_tready_i = 1'($urandom_range(0, 1));
                1: tx_tready_i = !tx_tready_i;
                2: tx_tready_i = 1'b1;
                default: tx_tready_i = 1'b0;
            endcase
        end
    end

    // Multiplier model: random accept delay, result 3 cycles after the handshake
    logic [31:0] ma, mb;
    int md;
    initial begin
        mul_ready_i = 1'b0;
        mul_done_i = 1'b0;
        mul_result_i = '0;
        forever begin
            @(posedge clk); #1;
            if (mul_valid_o && !rst) begin
                md = $urandom_range(0, 2);
                repeat (md) begin @(posedge clk); #1; end
                ma = mul_a_o;
                mb = mul_b_o;
                mul_ready_i = 1'b1;
                @(posedge clk); #1;
                mul_ready_i = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
                mul_result_i = ma * mb;
                mul_done_i = 1'b1;
                @(posedge clk); #1;
                mul_done_i = 1'b0;
            end
        end
    end

    // Compare process: every cycle, checked at the falling edge
    logic       pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("tx_hold_valid", tx_tvalid_o, 1);
                    check("tx_hold_data", tx_tdata_o, pd);
                end
                if (tx_tvalid_o && tx_tready_i) begin
                    if (exp_tx.size() == 0) flag("tx_extra_byte");
                    else check("tx_byte", tx_tdata_o, exp_tx.pop_front());
                    tx_count++;
                end
                if (err_o) begin
                    if (exp_err.size() == 0) flag("err_extra_pulse");
                    else check("err_code", err_code_o, exp_err.pop_front());
                end
                if (mul_valid_o && mul_ready_i) begin
                    if (exp_mul.size() == 0) flag("mul_extra_req");
                    else check("mul_req", {mul_a_o, mul_b_o}, exp_mul.pop_front());
                end
                pv = tx_tvalid_o;
                pr = tx_tready_i;
                pd = tx_tdata_o;
            end
        end
    end

    task automatic send_bytes(input byte unsigned p[$]);
        int n;
        foreach (p[i]) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            rx_tvalid_i = 1'b1;
            rx_tdata_i  = p[i];
            n = 0;
            forever begin
                @(negedge clk);
                if (rx_tready_o) break;
                n++;
                if (n > 2000) begin
                    $display("FAIL rx_accept_timeout: byte %0d never accepted", i);
                    $fatal(1);
                end
            end
            @(posedge clk); #1;
            rx_tvalid_i = 1'b0;
        end
    endtask

    task automatic run_pkt(input byte unsigned p[$]);
        model_pkt(p);
        foreach (m_tx[i]) exp_tx.push_back(m_tx[i]);
        foreach (m_mul[i]) exp_mul.push_back(m_mul[i]);
        if (m_err != 0) exp_err.push_back(m_err);
        send_bytes(p);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_tx.size() != 0 || exp_mul.size() != 0 || busy_o) begin
            @(posedge clk); #1;
            n++;
            if (n > 5000) begin
                flag("idle_timeout");
                break;
            end
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    byte unsigned p[$];
    byte unsigned lit[$];
    int cnt, base, kind, nbytes;
    logic [15:0] len;
    logic [7:0] op;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        rx_tvalid_i = 1'b0;
        rx_tdata_i = '0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_tx_valid", tx_tvalid_o, 0);
        check("rst_tx_data", tx_tdata_o, 0);
        check("rst_mul_valid", mul_valid_o, 0);
        check("rst_mul_ab", {mul_a_o, mul_b_o}, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", {err_o, err_code_o}, 0);
        rst = 1'b0;

        // echo with toggling TX ready
        tx_mode = 1;
        p = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h41, 8'h42, 8'h43, 8'h44};
        model_pkt(p);
        lit = '{8'h41, 8'h42, 8'h43, 8'h44};
        pin_tx("pin_echo", lit);
        run_pkt(p);
        wait_idle();

        // add with wrap-around
        tx_mode = 0;
        p = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        model_pkt(p);
        lit = '{8'h00, 8'h00, 8'h00, 8'h00};
        pin_tx("pin_add", lit);
        check("pin_add_err", m_err, 0);
        run_pkt(p);
        wait_idle();

        // multiply 3*5
        p = '{8'hB2, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        model_pkt(p);
        lit = '{8'h0F, 8'h00, 8'h00, 8'h00};
        pin_tx("pin_mul", lit);
        check("pin_mul_req", m_mul[0], {32'd3, 32'd5});
        run_pkt(p);
        wait_idle();

        // bad opcode then a normal echo
        p = '{8'h77, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        model_pkt(p);
        check("pin_badop_err", m_err, 1);
        check("pin_badop_tx", m_tx.size(), 0);
        run_pkt(p);
        p = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h51, 8'h52};
        run_pkt(p);
        wait_idle();

        // add with bad length 9: 5 bytes drained, next packet parses
        p = '{8'hA1, 8'h00, 8'h09, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        model_pkt(p);
        check("pin_badlen_err", m_err, 2);
        run_pkt(p);
        p = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h99};
        run_pkt(p);
        // echo LEN=4 (no output), echo LEN=2 (error), bad opcode LEN=0
        p = '{8'hEC, 8'h00, 8'h04, 8'h00};
        run_pkt(p);
        p = '{8'hEC, 8'h00, 8'h02, 8'h00};
        run_pkt(p);
        p = '{8'h10, 8'h00, 8'h00, 8'h00};
        run_pkt(p);
        p = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h61, 8'h62};
        run_pkt(p);
        wait_idle();

        // timeout after three header bytes
        exp_err.push_back(3);
        p = '{8'hEC, 8'h00, 8'h08};
        send_bytes(p);
        cnt = 0;
        while (cnt < 4 * T) begin
            @(posedge clk); #1;
            cnt++;
            if (err_o) break;
        end
        check("timeout_cycles", cnt, T);
        check("timeout_busy", busy_o, 0);
        wait_idle();
        p = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
        run_pkt(p);
        wait_idle();

        // reset in RESP after two bytes
        tx_mode = 2;
        p = '{8'hA1, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        model_pkt(p);
        lit = '{8'h78, 8'h56, 8'h34, 8'h12};
        pin_tx("pin_add1", lit);
        base = tx_count;
        run_pkt(p);
        cnt = 0;
        while (tx_count < base + 2 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_tx_valid", tx_tvalid_o, 0);
        check("rstmid_busy", busy_o, 0);
        check("rstmid_left", exp_tx.size(), 2);
        rst = 1'b0;
        exp_tx.delete();
        p = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
        run_pkt(p);
        wait_idle();

        // randomized packet stream
        tx_mode = 0;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 3) begin
                op = 8'hEC; len = 16'($urandom_range(5, 20));
            end else if (kind <= 7) begin
                op = (kind <= 5) ? 8'hA1 : 8'hB2;
                len = 16'(4 + 4 * $urandom_range(1, 4));
            end else if (kind == 8) begin
                op = 8'($urandom_range(0, 255));
                while (op == 8'hEC || op == 8'hA1 || op == 8'hB2) op = 8'($urandom_range(0, 255));
                len = 16'($urandom_range(0, 12));
            end else if ($urandom_range(0, 1) == 1) begin
                op = 8'hEC; len = 16'($urandom_range(0, 3));
            end else begin
                op = ($urandom_range(0, 1) == 1) ? 8'hA1 : 8'hB2;
                len = 16'($urandom_range(0, 15));
                if (len >= 8 && len[1:0] == 2'd0) len = len + 16'd1;
            end
            p.delete();
            p.push_back(op);
            p.push_back(8'($urandom_range(0, 255)));
            p.push_back(len[7:0]);
            p.push_back(len[15:8]);
            nbytes = (len > 4) ? int'(len) - 4 : 0;
            for (int i = 0; i < nbytes; i++) p.push_back(8'($urandom_range(0, 255)));
            run_pkt(p);
        end
        wait_idle();

        check("left_tx", exp_tx.size(), 0);
        check("left_err", exp_err.size(), 0);
        check("left_mul", exp_mul.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
